// File: rtl/lb_pkg.sv
// Shared types and helpers for the N-row line buffer: fill-state enum,
// index-width helper and tap slice offset helper.
package lb_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } fill_state_e;

    // A position counter is never narrower than one bit, even for a 1-wide image.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tap_lsb(input int tap, input int bw);
        return tap * bw;
    endfunction

endpackage

// File: rtl/row_delay.sv
// One COLS-deep circular row memory. The pointer is shared with the other rows,
// so dout is the pixel written exactly COLS accepted pixels earlier.
module row_delay
    import lb_pkg::*;
#(
    parameter int COLS      = 28,
    parameter int BIT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [idx_width(COLS)-1:0]  ptr,
    input  logic [BIT_WIDTH-1:0]        din,
    output logic [BIT_WIDTH-1:0]        dout
);

    logic [BIT_WIDTH-1:0] mem_q [COLS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COLS; i++) mem_q[i] <= '0;
        end else if (en) begin
            mem_q[ptr] <= din;
        end
    end

    // Read-before-write: the old entry at the pointer is the delayed pixel.
    assign dout = mem_q[ptr];

endmodule

// File: rtl/line_buffer_nrow.sv
// N-row streaming line buffer with position tracking and fill FSM.
// Optional KxK window register (K = NUM_ROWS+1) enabled by LINEBUF_WINDOW_EN.
module line_buffer_nrow
    import lb_pkg::*;
#(
    parameter int COLS      = 28,
    parameter int IMG_ROWS  = 28,
    parameter int NUM_ROWS  = 2,
    parameter int BIT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BIT_WIDTH-1:0]              rb_in,
    input  logic                              en,
    input  logic                              frame_start,
    output logic [NUM_ROWS*BIT_WIDTH-1:0]     rb_out,
    output logic [idx_width(COLS)-1:0]        col_idx,
    output logic [idx_width(IMG_ROWS)-1:0]    row_idx,
    output logic                              win_valid,
    output logic                              frame_done
`ifdef LINEBUF_WINDOW_EN
    ,
    output logic [(NUM_ROWS+1)*(NUM_ROWS+1)*BIT_WIDTH-1:0] win_out
`endif
);

    localparam int CW = idx_width(COLS);
    localparam int RW = idx_width(IMG_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [RW-1:0] FULL_ROW = RW'(NUM_ROWS);

    logic [CW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  colIdx_q;
    logic [RW-1:0]  rowIdx_q;
    logic [CW-1:0]  posCol;
    logic [RW-1:0]  posRow;
    logic           winValid_q, winValid_d;
    logic           frameDone_q, frameDone_d;
    logic           colOk;
    fill_state_e    state_q, state_d;
    logic [NUM_ROWS*BIT_WIDTH-1:0] rbOut_q;
    logic [BIT_WIDTH-1:0] tapOut [NUM_ROWS];

    // frame_start makes the pixel accepted this cycle count as (0,0).
    assign posCol = frame_start ? '0 : col_q;
    assign posRow = frame_start ? '0 : row_q;

    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_rows
        logic [BIT_WIDTH-1:0] rowIn;
        if (g == 0) begin : g_first
            assign rowIn = rb_in;
        end else begin : g_chain
            assign rowIn = tapOut[g-1];
        end
        row_delay #(.COLS(COLS), .BIT_WIDTH(BIT_WIDTH)) u_row (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .ptr  (ptr_q),
            .din  (rowIn),
            .dout (tapOut[g])
        );
    end

    always_comb begin
        ptr_d = ptr_q;
        col_d = col_q;
        row_d = row_q;
        if (en) begin
            ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + CW'(1);
            if (posCol == COL_LAST) begin
                col_d = '0;
                row_d = (posRow == ROW_LAST) ? '0 : posRow + RW'(1);
            end else begin
                col_d = posCol + CW'(1);
                row_d = posRow;
            end
        end else if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave STREAM when the first pixel of a new frame arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:   if (en && posRow == FULL_ROW) state_d = STREAM;
            STREAM: if (frame_start || (en && posRow == '0 && posCol == '0)) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

`ifdef LINEBUF_WINDOW_EN
    localparam int K = NUM_ROWS + 1;
    localparam logic [CW-1:0] WIN_COL_MIN = CW'(K - 1);
    assign colOk = (posCol >= WIN_COL_MIN);
`else
    assign colOk = 1'b1;
`endif

    always_comb begin
        winValid_d  = winValid_q;
        frameDone_d = 1'b0;
        if (en) begin
            winValid_d  = (state_d == STREAM) && colOk;
            frameDone_d = (posRow == ROW_LAST) && (posCol == COL_LAST);
        end else if (frame_start) begin
            winValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            colIdx_q    <= '0;
            rowIdx_q    <= '0;
            winValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            rbOut_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            winValid_q  <= winValid_d;
            frameDone_q <= frameDone_d;
            if (en) begin
                colIdx_q <= posCol;
                rowIdx_q <= posRow;
                for (int i = 0; i < NUM_ROWS; i++)
                    rbOut_q[tap_lsb(i, BIT_WIDTH) +: BIT_WIDTH] <= tapOut[i];
            end
        end
    end

`ifdef LINEBUF_WINDOW_EN
    logic [BIT_WIDTH-1:0] newCol [K];
    logic [BIT_WIDTH-1:0] win_q  [K][K];

    always_comb begin
        newCol[0] = rb_in;
        for (int r = 1; r < K; r++) newCol[r] = tapOut[r-1];
    end

    // Older columns are dropped at each row start so no window straddles rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) win_q[r][c] <= '0;
        end else if (en) begin
            for (int r = 0; r < K; r++) begin
                win_q[r][0] <= newCol[r];
                for (int c = 1; c < K; c++)
                    win_q[r][c] <= (posCol == '0) ? '0 : win_q[r][c-1];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_wr
        for (genvar c = 0; c < K; c++) begin : g_wc
            assign win_out[(r*K+c)*BIT_WIDTH +: BIT_WIDTH] = win_q[r][c];
        end
    end
`endif

    assign rb_out     = rbOut_q;
    assign col_idx    = colIdx_q;
    assign row_idx    = rowIdx_q;
    assign win_valid  = winValid_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_line_buffer_nrow.sv
// Randomised and directed bench for line_buffer_nrow against a pixel-history model.
// Also covers the LINEBUF_WINDOW_EN window output when that macro is defined.
module tb_line_buffer_nrow;

    localparam int C  = 4;
    localparam int R  = 4;
    localparam int N  = 2;
    localparam int BW = 8;
    localparam int K  = N + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [BW-1:0]     rb_in = '0;
    logic              en = 1'b0;
    logic              frame_start = 1'b0;
    logic [N*BW-1:0]   rb_out;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;
    logic              win_valid;
    logic              frame_done;
`ifdef LINEBUF_WINDOW_EN
    logic [K*K*BW-1:0] win_out;
`endif

    line_buffer_nrow #(.COLS(C), .IMG_ROWS(R), .NUM_ROWS(N), .BIT_WIDTH(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rb_in       (rb_in),
        .en          (en),
        .frame_start (frame_start),
        .rb_out      (rb_out),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .win_valid   (win_valid),
        .frame_done  (frame_done)
`ifdef LINEBUF_WINDOW_EN
        ,
        .win_out     (win_out)
`endif
    );

    always #5 clk = ~clk;

    int hist[$];
    int k;
    int expCol, expRow;
    logic expValid, expDone;
    int passCount = 0;
    int checkCount = 0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            passCount++;
    endtask

    // Pixel accepted 'back' enables before the most recent one; zero if none since reset.
    function automatic int histAt(input int back);
        int idx;
        idx = hist.size() - 1 - back;
        return (idx >= 0) ? hist[idx] : 0;
    endfunction

    function automatic logic [N*BW-1:0] expTaps();
        logic [N*BW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(histAt((i+1)*C - 1 + 1) );
        return v;
    endfunction

`ifdef LINEBUF_WINDOW_EN
    function automatic logic [K*K*BW-1:0] expWin();
        logic [K*K*BW-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                if (c <= expCol) v[(r*K+c)*BW +: BW] = BW'(histAt(c + r*C));
        return v;
    endfunction
`endif

    task automatic clearModel();
        hist.delete();
        k = 0;
        expCol = 0;
        expRow = 0;
        expValid = 1'b0;
        expDone = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        en = 1'b0;
        frame_start = 1'b0;
        clearModel();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic e, input logic fs, input logic [BW-1:0] px);
        en = e;
        frame_start = fs;
        rb_in = px;
        @(posedge clk);
        #1;
        en = 1'b0;
        frame_start = 1'b0;
        if (e) begin
            if (fs) k = 0;
            hist.push_back(int'(px));
            expCol = k % C;
            expRow = k / C;
            expValid = (expRow >= N);
`ifdef LINEBUF_WINDOW_EN
            expValid = expValid && (expCol >= K - 1);
`endif
            expDone = (k == C*R - 1);
            k = (k + 1) % (C*R);
        end else begin
            expDone = 1'b0;
        end
        checkOutput("taps", rb_out, expTaps());
        checkOutput("col_idx", col_idx, expCol[1:0]);
        checkOutput("row_idx", row_idx, expRow[1:0]);
        checkOutput("win_valid", win_valid, expValid);
        checkOutput("frame_done", frame_done, expDone);
`ifdef LINEBUF_WINDOW_EN
        checkOutput("win_out", win_out, expWin());
`endif
    endtask

    initial begin
        clearModel();
        #12;
        rst = 1'b1;
        checkOutput("rst_taps", rb_out, '0);
        checkOutput("rst_col", col_idx, 2'd0);
        checkOutput("rst_valid", win_valid, 1'b0);
        checkOutput("rst_done", frame_done, 1'b0);

        // Asynchronous reset in the middle of a row, checked before any edge.
        for (int p = 1; p <= 6; p++) applyStimulus(1'b1, 1'b0, BW'(p));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_taps", rb_out, '0);
        checkOutput("async_col", col_idx, 2'd0);
        checkOutput("async_row", row_idx, 2'd0);
        checkOutput("async_valid", win_valid, 1'b0);
        resetDut();

        // Continuous ramp through one frame and into the next.
        for (int p = 1; p <= 17; p++) begin
            applyStimulus(1'b1, 1'b0, BW'(p));
            if (p == 5) checkOutput("ramp_s0", rb_out[7:0], 8'd1);
            if (p == 9) checkOutput("ramp_s1", rb_out[15:8], 8'd1);
            if (p == 16) begin
                checkOutput("wrap_col", col_idx, 2'd3);
                checkOutput("wrap_done", frame_done, 1'b1);
                applyStimulus(1'b0, 1'b0, 8'hAA);
                checkOutput("done_clear", frame_done, 1'b0);
            end
            if (p == 17) checkOutput("wrap_valid", win_valid, 1'b0);
        end

        // Same ramp with idle cycles interleaved.
        resetDut();
        for (int p = 1; p <= 16; p++) begin
            applyStimulus(1'b1, 1'b0, BW'(p));
            applyStimulus(1'b0, 1'b0, BW'($urandom));
        end

        // frame_start restarts position but keeps stored rows.
        resetDut();
        for (int p = 1; p <= 12; p++) begin
            applyStimulus(1'b1, (p == 7), BW'(p));
            if (p == 7) checkOutput("fs_col", col_idx, 2'd0);
            if (p == 8) checkOutput("fs_next_col", col_idx, 2'd1);
        end

        // Random traffic with sporadic restarts.
        resetDut();
        for (int i = 0; i < 600; i++) begin
            logic e;
            e = ($urandom % 4) != 0;
            applyStimulus(e, e && (($urandom % 32) == 0), BW'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/line_buffer_nrow.md
Name: line_buffer_nrow

Overview:
- Parametrised N-row line buffer for streaming convolution/pooling front-ends.
- Accepts one pixel per enabled cycle in raster order. Presents the same column position from each of the previous NUM_ROWS image rows.
- Tracks column, row and frame position, and flags when a full vertical window is available.
- Sits between the pixel source and the conv/pool windowing stages; generalises the fixed two-row buffer.

Parameters:
- COLS, 28, image width in pixels (row length).
- IMG_ROWS, 28, image height in rows (frame length).
- NUM_ROWS, 2, number of stored rows / output taps (>=1).
- BIT_WIDTH, 8, pixel width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rb_in  in  BIT_WIDTH  input pixel.
- en  in  1  accept rb_in this cycle; all state holds when 0.
- frame_start  in  1  synchronous restart of position counters and fill state.
- rb_out  out  NUM_ROWS*BIT_WIDTH  taps; slice i = [i*BIT_WIDTH +: BIT_WIDTH] = pixel accepted (i+1)*COLS enables earlier.
- col_idx  out  $clog2(COLS)  column of the most recently accepted pixel.
- row_idx  out  $clog2(IMG_ROWS)  row of the most recently accepted pixel.
- win_valid  out  1  current taps plus last pixel form a valid vertical window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=0, async): all stored pixels = 0, rb_out = 0, col/row counters = 0, col_idx = row_idx = 0, win_valid = 0, frame_done = 0, FSM = FILL.
- Storage: NUM_ROWS chained row delays, each COLS deep. Built as a circular memory with one shared write/read pointer (0..COLS-1, wraps at COLS-1); no per-pixel shift chain.
- On a rising edge with en=1:
  - row 0 writes rb_in; row i writes row i-1's old output at the pointer; pointer advances.
  - rb_out is registered and reflects the new contents after the edge.
- Latency: rb_out slice i equals rb_in from exactly (i+1)*COLS accepted pixels earlier. Idle cycles (en=0) do not count.
- Counters, on each accepted pixel:
  - col increments and wraps at COLS-1, where row increments.
  - row wraps at IMG_ROWS-1 on the last column.
  - col_idx/row_idx register the position of the pixel just accepted.
- FSM:
  - FILL -> STREAM on the accepting edge where the pixel's row index == NUM_ROWS (first pixel whose rows above are all stored).
  - STREAM -> FILL on frame wrap or frame_start.
- win_valid: updated only on accepting edges; set to (FSM==STREAM after that edge); held when en=0.
- frame_done: pulses 1 for exactly the cycle after the edge accepting (row IMG_ROWS-1, col COLS-1); 0 otherwise.
- frame_start=1 (sync, priority over counter increment):
  - counters reset to 0, FSM -> FILL, win_valid -> 0.
  - Stored data is not cleared.
  - If en=1 in the same cycle, the pixel is stored and treated as (0,0), so the counters become col 1, row 0.
- en=0 with frame_start=0: nothing changes, including frame_done (which still self-clears).
- NUM_ROWS=2 defaults reproduce the existing two-row buffer tap timing exactly.

Optional Feature:
- Macro: LINEBUF_WINDOW_EN.
- With it defined:
  - adds output win_out of K*K*BIT_WIDTH, K = NUM_ROWS+1: a K-column shift register over {rb_in, taps}, shifted on each accepted pixel.
  - win_out element (r,c) = [(r*K+c)*BIT_WIDTH +: BIT_WIDTH]; r=0 is the newest row, c=0 the newest column.
  - The horizontal register resets to 0, and its column history is cleared at each row start.
  - win_valid additionally requires col_idx >= K-1.
- Without it: no win_out, no horizontal registers; win_valid uses row fill only.

Decomposition:
- Shared package lb_pkg:
  - fill-FSM state typedef (FILL, STREAM).
  - clog2-based width constants.
  - tap slice index helper.
- One natural sub-module, row_delay: a single COLS-deep, BIT_WIDTH-wide circular row memory with external pointer and enable, instantiated NUM_ROWS times in a generate loop.
- Counters, FSM and the optional window register stay in the top.

Test Plan (COLS=4, IMG_ROWS=4, NUM_ROWS=2, BIT_WIDTH=8):
- Reset mid-stream: feed 6 pixels, pull rst low asynchronously -> rb_out=0, col_idx=row_idx=0, win_valid=0 immediately, without waiting for a clock edge.
- Ramp 1..16 with en=1 continuously -> slice 0 = 1 after pixel 5, slice 1 = 1 after pixel 9; win_valid rises after pixel 9 (row 2, col 0).
- Same ramp with en toggled 1/0 -> identical tap values, each arriving on the corresponding accepting edge; outputs held during en=0 cycles.
- Frame wrap: after pixel 16 -> frame_done=1 for exactly one cycle, col_idx=3, row_idx=3; pixel 17 -> col_idx=0, row_idx=0, win_valid=0.
- frame_start with en=1 at pixel 7 -> col_idx=0, row_idx=0; next pixel gives col_idx=1; win_valid stays 0 until row 2; taps still show old data.
- With LINEBUF_WINDOW_EN (K=3), ramp 1..16 -> win_valid first at pixel 11 with win_out rows {11,10,9},{7,6,5},{3,2,1}.
